// File: rtl/shared_pkg.sv
// Shared types and constants for the SPI slave: FSM state encoding, word widths
// and the two-bit command codes carried in the top bits of each received frame.
package shared_pkg;

  localparam int RX_W = 10;
  localparam int TX_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } spi_state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave_fsm_tx_shifter.sv
// Read-data serializer: loads tx_data on tx_valid while armed, then shifts it
// onto miso MSB first, one bit per clock, and raises done until cleared.
module spi_tx_shifter #(
  parameter int TX_W = shared_pkg::TX_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            arm,
  input  logic            tx_valid,
  input  logic [TX_W-1:0] tx_data,
  output logic            miso,
  output logic            busy,
  output logic            done
);

  localparam int CNT_W = $clog2(TX_W + 1);

  logic [TX_W-1:0]  shreg;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
      miso  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (clr) begin
      shreg <= '0;
      cnt   <= '0;
      miso  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (busy) begin
      // cnt counts bits already presented; the edge after the last bit idles miso
      if (cnt == CNT_W'(TX_W)) begin
        miso <= 1'b0;
        busy <= 1'b0;
        done <= 1'b1;
        cnt  <= '0;
      end else begin
        miso  <= shreg[TX_W-1];
        shreg <= {shreg[TX_W-2:0], 1'b0};
        cnt   <= cnt + CNT_W'(1);
      end
    end else if (arm && !done && tx_valid) begin
      miso  <= tx_data[TX_W-1];
      shreg <= {tx_data[TX_W-2:0], 1'b0};
      cnt   <= CNT_W'(1);
      busy  <= 1'b1;
    end
  end

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI slave front end for a command/address/data RAM port. Optional embedded
// protocol assertions are compiled in when SPI_SLAVE_FSM_ASSERT_EN is defined.
module spi_slave_fsm #(
  parameter int RX_W = shared_pkg::RX_W,
  parameter int TX_W = shared_pkg::TX_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            SS_n,
  input  logic            MOSI,
  output logic            MISO,
  output logic [RX_W-1:0] rx_data,
  output logic            rx_valid,
  input  logic [TX_W-1:0] tx_data,
  input  logic            tx_valid
);

  import shared_pkg::spi_state_e, shared_pkg::IDLE, shared_pkg::CHK_CMD,
         shared_pkg::WRITE, shared_pkg::READ_ADD, shared_pkg::READ_DATA;

  localparam int CNT_W = $clog2(RX_W + 1);

  spi_state_e       state, state_nxt;
  logic [CNT_W-1:0] rx_cnt;
  logic [RX_W-1:0]  rx_shreg;
  logic             rd_addr_flag;
  logic             rx_done;
  logic             ss_armed;
  logic             shift_en;
  logic             last_bit;
  logic             tx_arm;
  logic             tx_busy;
  logic             tx_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        if (!SS_n && ss_armed) state_nxt = CHK_CMD;
      end
      CHK_CMD: begin
        if (SS_n)              state_nxt = IDLE;
        else if (!MOSI)        state_nxt = WRITE;
        else if (rd_addr_flag) state_nxt = READ_DATA;
        else                   state_nxt = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (SS_n) state_nxt = IDLE;
        else      shift_en  = !rx_done;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign last_bit = shift_en && (rx_cnt == CNT_W'(RX_W - 1));
  assign tx_arm   = (state == READ_DATA) && rx_done && !SS_n;

  // ss_armed blocks a frame from starting until SS_n has been seen high,
  // so a reset released with SS_n still low cannot enter a half-frame.
  // NOTE: the receive shift register is cleared by reset like any other
  // register; it is only a few flops, not a memory array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt       <= '0;
      rx_shreg     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_flag <= 1'b0;
      rx_done      <= 1'b0;
      ss_armed     <= 1'b0;
    end else begin
      rx_valid <= last_bit;
      if (SS_n) begin
        ss_armed <= 1'b1;
        rx_cnt   <= '0;
        rx_shreg <= '0;
        rx_done  <= 1'b0;
      end else if (shift_en) begin
        rx_shreg <= {rx_shreg[RX_W-2:0], MOSI};
        if (last_bit) begin
          rx_data <= {rx_shreg[RX_W-2:0], MOSI};
          rx_cnt  <= '0;
          rx_done <= 1'b1;
          if (state == READ_ADD)       rd_addr_flag <= 1'b1;
          else if (state == READ_DATA) rd_addr_flag <= 1'b0;
        end else begin
          rx_cnt <= rx_cnt + CNT_W'(1);
        end
      end
    end
  end

  spi_tx_shifter #(
    .TX_W(TX_W)
  ) u_tx_shifter (
    .clk      (clk),
    .rst      (rst),
    .clr      (SS_n),
    .arm      (tx_arm),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .miso     (MISO),
    .busy     (tx_busy),
    .done     (tx_done)
  );

`ifdef SPI_SLAVE_FSM_ASSERT_EN
  a_rx_valid_single : assert property (@(posedge clk) disable iff (rst)
    rx_valid |=> !rx_valid);
  a_miso_quiet : assert property (@(posedge clk) disable iff (rst)
    (state != READ_DATA) |-> !MISO);
  a_ss_to_idle : assert property (@(posedge clk) disable iff (rst)
    SS_n |=> (state == IDLE));
  a_rd_data_cmd : assert property (@(posedge clk) disable iff (rst)
    (rx_valid && state == READ_DATA) |-> (rx_data[RX_W-1 -: 2] == shared_pkg::CMD_RD_DATA));
  a_tx_status : assert property (@(posedge clk) disable iff (rst)
    !(tx_busy && tx_done));
`else
  // Assertion-free build: behaviour is identical, only the checkers are absent.
`endif

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Self-checking bench for spi_slave_fsm: directed frames plus randomized frames
// checked against a frame-level model of command decoding and read-data return.
module tb_spi_slave_fsm;
  import shared_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            SS_n;
  logic            MOSI;
  logic            MISO;
  logic [RX_W-1:0] rx_data;
  logic            rx_valid;
  logic [TX_W-1:0] tx_data;
  logic            tx_valid;

  int total = 0;
  int bad   = 0;
  bit model_flag = 1'b0;

  always #5 clk = ~clk;

  spi_slave_fsm #(
    .RX_W(RX_W),
    .TX_W(TX_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete frame: select, command bit, RX_W data bits, optional read
  // return, a few trailing clocks with SS_n still low, then deselect.
  task automatic run_frame(input logic cmd, input logic [RX_W-1:0] word,
                           input int tx_delay, input logic [TX_W-1:0] txd,
                           input bit stray_tx);
    bit         is_rd_data;
    int         early;
    spi_state_e exp_state;
    is_rd_data = cmd && model_flag;
    exp_state  = !cmd ? WRITE : (model_flag ? READ_DATA : READ_ADD);
    early      = 0;

    SS_n     = 1'b0;
    MOSI     = 1'($urandom);
    tx_valid = stray_tx;
    tx_data  = TX_W'($urandom);
    step();
    MOSI = cmd;
    step();
    check("cmd_state", 32'(dut.state), 32'(exp_state));
    for (int i = RX_W - 1; i >= 0; i--) begin
      MOSI = word[i];
      step();
      check("miso_during_rx", MISO, 1'b0);
      if (i > 0) early += int'(rx_valid);
    end
    check("early_rx_valid", early, 0);
    check("rx_valid_pulse", rx_valid, 1'b1);
    check("rx_data", rx_data, word);
    if (cmd) model_flag = !model_flag;
    check("rd_addr_flag", dut.rd_addr_flag, model_flag);

    tx_valid = 1'b0;
    if (is_rd_data) begin
      for (int d = 0; d < tx_delay; d++) begin
        step();
        check("miso_wait", MISO, 1'b0);
        if (d == 0) check("rx_valid_drop", rx_valid, 1'b0);
      end
      tx_valid = 1'b1;
      tx_data  = txd;
      step();
      tx_valid = 1'b0;
      tx_data  = TX_W'($urandom);
      check("rx_valid_low_tx", rx_valid, 1'b0);
      check("miso_msb", MISO, txd[TX_W-1]);
      for (int b = TX_W - 2; b >= 0; b--) begin
        step();
        check("miso_bit", MISO, txd[b]);
      end
      step();
      check("miso_after_shift", MISO, 1'b0);
    end

    tx_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      MOSI    = 1'($urandom);
      tx_data = TX_W'($urandom);
      step();
      check("post_frame_miso", MISO, 1'b0);
      check("post_frame_valid", rx_valid, 1'b0);
    end
    tx_valid = 1'b0;
    SS_n     = 1'b1;
    step();
    check("deselect_idle", 32'(dut.state), 32'(IDLE));
    check("rx_data_hold", rx_data, word);
  endtask

  initial begin
    logic            cmd;
    logic [RX_W-1:0] word;
    logic [TX_W-1:0] txd;

    rst      = 1'b1;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (3) step();
    check("rst_state", 32'(dut.state), 32'(IDLE));
    check("rst_miso", MISO, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, '0);
    check("rst_flag", dut.rd_addr_flag, 1'b0);
    rst = 1'b0;
    step();

    // Write address with a stray tx_valid held through the frame
    run_frame(1'b0, 10'h0A5, 0, 8'h00, 1'b1);
    // Write data
    run_frame(1'b0, 10'h1F0, 0, 8'h00, 1'b0);
    // Read address then read data returning 0xC3 immediately
    run_frame(1'b1, 10'h203, 0, 8'h00, 1'b0);
    run_frame(1'b1, 10'h300, 0, 8'hC3, 1'b0);
    // Read data with tx_valid delayed by 5 cycles
    run_frame(1'b1, 10'h2_5A, 0, 8'h00, 1'b0);
    run_frame(1'b1, 10'h3_11, 5, 8'h96, 1'b0);

    // Deselect after 4 payload bits aborts the frame
    SS_n = 1'b0;
    step();
    MOSI = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      MOSI = 1'($urandom);
      step();
    end
    SS_n = 1'b1;
    step();
    check("abort_idle", 32'(dut.state), 32'(IDLE));
    check("abort_no_valid", rx_valid, 1'b0);
    step();
    check("abort_no_valid_late", rx_valid, 1'b0);
    check("abort_rx_data_hold", rx_data, 10'h3_11);
    run_frame(1'b0, 10'h1_3C, 0, 8'h00, 1'b0);

    // Reset asserted in the middle of a MISO shift
    run_frame(1'b1, 10'h2_77, 0, 8'h00, 1'b0);
    SS_n = 1'b0;
    step();
    MOSI = 1'b1;
    step();
    word = 10'h3_E4;
    for (int i = RX_W - 1; i >= 0; i--) begin
      MOSI = word[i];
      step();
    end
    check("rst_test_rx_valid", rx_valid, 1'b1);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    step();
    tx_valid = 1'b0;
    step();
    step();
    check("rst_test_shifting", MISO, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_miso", MISO, 1'b0);
    check("rst_async_valid", rx_valid, 1'b0);
    check("rst_async_flag", dut.rd_addr_flag, 1'b0);
    model_flag = 1'b0;
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      MOSI = 1'b1;
      step();
      check("rst_wait_ss_rise", 32'(dut.state), 32'(IDLE));
    end
    SS_n = 1'b1;
    step();
    run_frame(1'b1, 10'h2_C8, 0, 8'h00, 1'b0);

    // Randomized frames against the frame-level model
    for (int n = 0; n < 16; n++) begin
      cmd = 1'($urandom);
      if (!cmd)            word = {1'b0, 9'($urandom)};
      else if (!model_flag) word = {CMD_RD_ADDR, 8'($urandom)};
      else                  word = {CMD_RD_DATA, 8'($urandom)};
      txd = TX_W'($urandom);
      run_frame(cmd, word, int'($urandom_range(0, 6)), txd, bit'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_fsm.md
SPI_SLAVE_FSM -- requirements
Module: spi_slave_fsm

Interface
REQ-001 SHALL have parameter: RX_W, default 10, meaning the width of the receive word (2 command bits plus 8 payload bits).
REQ-002 SHALL have parameter: TX_W, default 8, meaning the width of the read-data word shifted out on MISO.
REQ-003 SHALL have port: clk  input  1  system clock; all sequential logic samples on its rising edge.
REQ-004 SHALL have port: rst  input  1  reset; asynchronous and active-high.
REQ-005 SHALL have port: SS_n  input  1  slave select, active-low; a frame runs while it is low.
REQ-006 SHALL have port: MOSI  input  1  serial data from the master, MSB first.
REQ-007 SHALL have port: MISO  output  1  serial read data to the master, MSB first.
REQ-008 SHALL have port: rx_data  output  RX_W  parallel frame to the RAM, with command in [9:8] and payload in [7:0].
REQ-009 SHALL have port: rx_valid  output  1  one-cycle strobe qualifying rx_data.
REQ-010 SHALL have port: tx_data  input  TX_W  read data returned by the RAM.
REQ-011 SHALL have port: tx_valid  input  1  qualifies tx_data for one or more cycles.

Function
REQ-012 SHALL implement the states IDLE, CHK_CMD, WRITE, READ_ADD and READ_DATA.
REQ-013 IDLE SHALL go to CHK_CMD on the first rising edge at which SS_n=0.
REQ-014 CHK_CMD SHALL go to WRITE when MOSI=0; when MOSI=1, it SHALL go to READ_ADD if rd_addr_flag=0, otherwise to READ_DATA; this command bit is not shifted in.
REQ-015 WRITE, READ_ADD and READ_DATA SHALL shift MOSI into a RX_W-bit shift register, one bit per cycle, MSB first; the first bit shifted in is the first bit after the command bit.
REQ-016 After the RX_W-th bit is sampled, the block SHALL drive rx_data from the shift register and assert rx_valid high for exactly one cycle on the next cycle.
REQ-017 In READ_ADD, when rx_valid asserts, rd_addr_flag SHALL be set to 1; in READ_DATA, when rx_valid asserts, rd_addr_flag SHALL be cleared to 0.
REQ-018 In READ_DATA after rx_valid, the block SHALL wait for tx_valid=1, then latch tx_data and drive MISO from bit TX_W-1 down to bit 0, one bit per cycle, starting the cycle after the latch.
REQ-019 MISO SHALL be a registered output that is 0 whenever the block is not shifting read data.
REQ-020 A tx_valid asserted outside the READ_DATA wait phase SHALL be ignored.
REQ-021 SS_n=1 in any state SHALL return the FSM to IDLE on the next edge, clear the bit counters and suppress any pending rx_valid; rd_addr_flag SHALL be retained.
REQ-022 The frame SHALL be finished when its MISO shift completes or its rx_valid pulse is issued; further clocks with SS_n=0 SHALL hold the FSM in its current state with no output activity until SS_n=1.
REQ-023 rx_data SHALL hold its last value between rx_valid pulses.

Reset
REQ-024 While rst=1, the block SHALL set state=IDLE, MISO=0, rx_valid=0, rx_data=0, rd_addr_flag=0, and clear all counters and shift registers.
REQ-025 rst asserted mid-frame SHALL abort the frame immediately with no rx_valid pulse; after rst is released, the block SHALL wait for SS_n to rise and then fall again.

Configuration
REQ-026 When SPI_SLAVE_FSM_ASSERT_EN is defined, the block SHALL compile in embedded concurrent assertions checking: rx_valid is never high for 2 consecutive cycles; MISO=0 outside READ_DATA; the FSM is in IDLE one cycle after SS_n=1; and rx_data[9:8]==2'b11 whenever rx_valid is high in READ_DATA.
REQ-027 When SPI_SLAVE_FSM_ASSERT_EN is undefined, the block SHALL contain no assertion code and its functional behaviour SHALL be identical.

Structure
REQ-028 shared_pkg SHALL hold the state enum spi_state_e, the constants RX_W and TX_W, and the command codes CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10 and CMD_RD_DATA=2'b11.
REQ-029 The design SHALL have a single sub-module, spi_tx_shifter, which handles the load-on-tx_valid operation and the MSB-first MISO shift with a done flag.

Verification
REQ-030 A bench SHALL cover: SS_n low, MOSI bits 0 then 00_1010_0101 -> one rx_valid pulse with rx_data=10'h0A5, and MISO=0 throughout.
REQ-031 A bench SHALL cover: write-data frame 0 then 01_1111_0000 -> rx_data=10'h1F0, and rd_addr_flag stays 0.
REQ-032 A bench SHALL cover: read address 1 then 10_0000_0011 -> rx_data=10'h203 and rd_addr_flag=1; then read data 1 then 11_0000_0000 with tx_data=8'hC3, tx_valid=1 -> MISO serializes 1,1,0,0,0,0,1,1 and rd_addr_flag=0.
REQ-033 A bench SHALL cover: read-data frame with tx_valid delayed by 5 cycles -> MISO stays 0 until the cycle after tx_valid.
REQ-034 A bench SHALL cover: SS_n raised after 4 payload bits -> no rx_valid pulse, the FSM is in IDLE the next cycle, and the next frame decodes correctly.
REQ-035 A bench SHALL cover: rst pulsed during a MISO shift -> MISO=0 and rx_valid=0 immediately, and the next read frame goes to READ_ADD.
